// File: rtl/prbs_lfsr.sv
// -----------------------------------------------------------------------------
// prbs_lfsr -- configurable PRBS generator with Fibonacci and Galois step rules.
//
// The state register advances one step per enabled cycle using either the
// Fibonacci rule (XOR of tapped bits shifted in at the LSB) or the Galois rule
// (shift left, XOR polynomial when the MSB falls out). The step rule is chosen
// per stepping cycle by galois_i. A loadable seed register remembers the
// sequence start so a return to it can be flagged with a one-cycle wrap pulse.
// An enabled step from the all-zero state recovers to SEED and sets a sticky
// lockup flag.
//
// Optional feature (macro LFSR_PERIOD_CNT_EN): a WIDTH-bit step counter that
// measures the sequence period; the value is published on period_out_o at
// every wrap. Without the macro there is no counter and period_out_o is 0.
//
// Ports:
//   clk_i        clock, all state changes on the rising edge
//   rst_i        synchronous active-high reset
//   en_i         advance one step this cycle
//   load_i       load seed_in_i into state and seed register (beats en_i)
//   seed_in_i    seed value captured on load_i
//   galois_i     step rule: 0 Fibonacci, 1 Galois
//   data_out_o   current state
//   bit_out_o    MSB of current state
//   wrap_o       registered pulse: the last step returned to the seed
//   lockup_o     sticky: an enabled cycle found the all-zero state
//   period_out_o last measured sequence period (0 without the macro)
// -----------------------------------------------------------------------------
module prbs_lfsr #(
  parameter int unsigned       WIDTH    = 8,
  parameter logic [WIDTH-1:0]  FIB_TAPS = 8'h8E,
  parameter logic [WIDTH-1:0]  GAL_POLY = 8'h1D,
  parameter logic [WIDTH-1:0]  SEED     = 8'h01
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_in_i,
  input  logic             galois_i,
  output logic [WIDTH-1:0] data_out_o,
  output logic             bit_out_o,
  output logic             wrap_o,
  output logic             lockup_o,
  output logic [WIDTH-1:0] period_out_o
);

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic             wrap_q, wrap_d;
  logic             lockup_q, lockup_d;

  logic [WIDTH-1:0] fib_next_s;
  logic [WIDTH-1:0] gal_next_s;
  logic [WIDTH-1:0] step_next_s;
  logic             zero_state_s;
  logic             step_s;

  // Candidate next states for both step rules.
  always_comb begin
    fib_next_s   = {state_q[WIDTH-2:0], ^(state_q & FIB_TAPS)};
    gal_next_s   = {state_q[WIDTH-2:0], 1'b0} ^ (state_q[WIDTH-1] ? GAL_POLY : {WIDTH{1'b0}});
    step_next_s  = galois_i ? gal_next_s : fib_next_s;
    zero_state_s = (state_q == {WIDTH{1'b0}});
    // A real step only happens when enabled, not loading, and not recovering.
    step_s       = en_i && !load_i && !zero_state_s;
  end

  // Next-state selection: load beats en; en on zero state recovers to SEED.
  always_comb begin
    state_d  = state_q;
    seed_d   = seed_q;
    wrap_d   = 1'b0;
    lockup_d = lockup_q;
    if (load_i) begin
      state_d  = seed_in_i;
      seed_d   = seed_in_i;
      lockup_d = 1'b0;
    end else if (en_i) begin
      if (zero_state_s) begin
        state_d  = SEED;
        lockup_d = 1'b1;
      end else begin
        state_d = step_next_s;
        wrap_d  = (step_next_s == seed_q);
      end
    end else begin
      state_d = state_q;
    end
  end

  // Core state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= SEED;
      seed_q   <= SEED;
      wrap_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      seed_q   <= seed_d;
      wrap_q   <= wrap_d;
      lockup_q <= lockup_d;
    end
  end

`ifdef LFSR_PERIOD_CNT_EN
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] cnt_inc_s;

  // Period counter: counts real steps, restarts on load and on every wrap.
  always_comb begin
    cnt_inc_s = (cnt_q == {WIDTH{1'b1}}) ? cnt_q : cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
    cnt_d     = cnt_q;
    period_d  = period_q;
    if (load_i) begin
      cnt_d = {WIDTH{1'b0}};
    end else if (step_s) begin
      if (wrap_d) begin
        // The wrapping step itself completes the period, hence counter+1.
        cnt_d    = {WIDTH{1'b0}};
        period_d = cnt_inc_s;
      end else begin
        cnt_d = cnt_inc_s;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Period counter and published period registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= {WIDTH{1'b0}};
      period_q <= {WIDTH{1'b0}};
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
    end
  end

  assign period_out_o = period_q;
`else
  assign period_out_o = {WIDTH{1'b0}};
`endif

  assign data_out_o = state_q;
  assign bit_out_o  = state_q[WIDTH-1];
  assign wrap_o     = wrap_q;
  assign lockup_o   = lockup_q;

endmodule

// File: tb/tb_prbs_lfsr.sv
// -----------------------------------------------------------------------------
// tb_prbs_lfsr -- directed self-checking bench for prbs_lfsr (default params).
// Inputs are driven just after a falling edge, outputs are sampled on the next
// falling edge, so each "apply; @(negedge)" pair is one rising edge of effect.
// -----------------------------------------------------------------------------
module tb_prbs_lfsr;

  logic       clk;
  logic       rst;
  logic       en;
  logic       load;
  logic [7:0] seed_in;
  logic       galois;
  logic [7:0] data_out;
  logic       bit_out;
  logic       wrap;
  logic       lockup;
  logic [7:0] period_out;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef LFSR_PERIOD_CNT_EN
  localparam logic [7:0] EXP_PERIOD = 8'd255;
`else
  localparam logic [7:0] EXP_PERIOD = 8'd0;
`endif

  prbs_lfsr dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (en),
    .load_i       (load),
    .seed_in_i    (seed_in),
    .galois_i     (galois),
    .data_out_o   (data_out),
    .bit_out_o    (bit_out),
    .wrap_o       (wrap),
    .lockup_o     (lockup),
    .period_out_o (period_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  logic [7:0] fib_exp [4];
  logic [7:0] gal_exp [9];
  logic       early_wrap;

  initial begin
    fib_exp = '{8'h02, 8'h05, 8'h0B, 8'h16};
    gal_exp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1D, 8'h3A};

    rst = 1'b1; en = 1'b0; load = 1'b0; seed_in = 8'h00; galois = 1'b0;
    cyc();
    chk("reset_data", data_out, 8'h01);
    chk("reset_wrap", wrap, 1'b0);
    chk("reset_lockup", lockup, 1'b0);
    chk("reset_period", period_out, 8'h00);
    chk("reset_bit", bit_out, 1'b0);

    // Fibonacci sequence from reset.
    rst = 1'b0; en = 1'b1; galois = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk($sformatf("fib_step%0d", i), data_out, fib_exp[i]);
    end

    // Galois sequence from reset.
    rst = 1'b1; en = 1'b0;
    cyc();
    rst = 1'b0; en = 1'b1; galois = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cyc();
      chk($sformatf("gal_step%0d", i), data_out, gal_exp[i]);
      if (i == 6) chk("gal_bit_out_80", bit_out, 1'b1);
    end

    // Toggling galois while idle keeps state; next step uses Fibonacci rule.
    en = 1'b0; galois = 1'b0;
    cyc();
    chk("rule_change_hold", data_out, 8'h3A);
    en = 1'b1;
    cyc();
    chk("rule_change_fib_step", data_out, 8'h74);

    // Full Fibonacci period: returns to 01 after 255 steps.
    rst = 1'b1; en = 1'b0;
    cyc();
    rst = 1'b0; en = 1'b1; galois = 1'b0;
    early_wrap = 1'b0;
    for (int i = 0; i < 254; i++) begin
      cyc();
      if (wrap === 1'b1 || data_out === 8'h01) early_wrap = 1'b1;
    end
    chk("period_no_early_wrap", early_wrap, 1'b0);
    cyc();
    chk("period_data", data_out, 8'h01);
    chk("period_wrap", wrap, 1'b1);
    chk("period_value", period_out, EXP_PERIOD);
    en = 1'b0;
    cyc();
    chk("period_wrap_one_cycle", wrap, 1'b0);
    chk("period_hold", period_out, EXP_PERIOD);

    // load with en in the same cycle: load wins.
    load = 1'b1; en = 1'b1; seed_in = 8'h5A;
    cyc();
    chk("load_en_data", data_out, 8'h5A);
    chk("load_en_wrap", wrap, 1'b0);
    chk("load_en_lockup", lockup, 1'b0);
    load = 1'b0; en = 1'b1;
    cyc();
    chk("load_then_step", data_out, 8'hB4);

    // Zero seed and lockup recovery.
    load = 1'b1; en = 1'b0; seed_in = 8'h00;
    cyc();
    chk("zero_load_data", data_out, 8'h00);
    chk("zero_load_lockup", lockup, 1'b0);
    load = 1'b0; en = 1'b1;
    cyc();
    chk("zero_recover_data", data_out, 8'h01);
    chk("zero_recover_lockup", lockup, 1'b1);
    chk("zero_recover_wrap", wrap, 1'b0);
    cyc();
    chk("lockup_sticky_data", data_out, 8'h02);
    chk("lockup_sticky", lockup, 1'b1);

    // Reset mid-run beats load and en.
    rst = 1'b1; load = 1'b1; en = 1'b1; seed_in = 8'hFF;
    cyc();
    chk("midrst_data", data_out, 8'h01);
    chk("midrst_wrap", wrap, 1'b0);
    chk("midrst_lockup", lockup, 1'b0);
    chk("midrst_period", period_out, 8'h00);
    rst = 1'b0; load = 1'b0; en = 1'b0;
    cyc();
    chk("idle_hold", data_out, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
